// File: rtl/vga_scan_timing_if.sv
// vga_scan_timing_if
//   Bundles everything the scan timing block exchanges with the display
//   colour logic and the VGA connector. clk and rst are kept outside.
//   master : the timing block (drives coordinates and connector pins,
//            receives the pixel strobe and returned colour)
//   slave  : the display side (drives strobe and colour, watches the rest)
interface vga_scan_timing_if;
  logic               i_pix_stb;
  logic [7:0]         i_red;
  logic [7:0]         i_green;
  logic [7:0]         i_blue;
  logic signed [15:0] o_x;
  logic signed [15:0] o_y;
  logic               o_de;
  logic               o_frame;
  logic               o_line;
  logic [7:0]         vga_r;
  logic [7:0]         vga_g;
  logic [7:0]         vga_b;
  logic               vga_hs;
  logic               vga_vs;

  modport master (
    input  i_pix_stb, i_red, i_green, i_blue,
    output o_x, o_y, o_de, o_frame, o_line,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  modport slave (
    output i_pix_stb, i_red, i_green, i_blue,
    input  o_x, o_y, o_de, o_frame, o_line,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs
  );
endinterface

// File: rtl/vga_scan_timing.sv
// vga_scan_timing
//   Pixel scan generator for the video path. Walks x/y over the full
//   raster (active area plus porches and sync), hands the position to the
//   display colour logic, and drives the VGA connector with the colour it
//   returns. Data-enable and the two syncs are delayed by PIX_LAT clocks so
//   they line up with colour that arrives PIX_LAT clocks after the
//   coordinates, then everything passes through one output register.
// Ports
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   scan  : vga_scan_timing_if.master
//           i_pix_stb          advance one pixel on this clk
//           i_red/green/blue   colour from the display logic
//           o_x/o_y            current position (never negative)
//           o_de               position is in the active area
//           o_frame/o_line     one-clk pulses on entering (0,0) / x=0
//           vga_r/g/b/hs/vs    connector pins
module vga_scan_timing #(
  parameter int H_RES   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_RES   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int PIX_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  vga_scan_timing_if.master scan
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT   = 16'(H_RES);
  localparam logic [15:0] V_ACT   = 16'(V_RES);
  localparam logic [15:0] HS_BEG  = 16'(H_RES + H_FP);
  localparam logic [15:0] HS_END  = 16'(H_RES + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG  = 16'(V_RES + V_FP);
  localparam logic [15:0] VS_END  = 16'(V_RES + V_FP + V_SYNC);

  function automatic logic in_window(input logic [15:0] v,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  function automatic logic [7:0] blank_colour(input logic vld,
                                              input logic [7:0] c);
    return vld ? c : 8'd0;
  endfunction

  // Counters are kept unsigned internally; the signed view is only for the
  // display logic's port type.
  logic [15:0] x_p0, y_p0;
  logic [15:0] x_nxt, y_nxt;
  logic        vld_p0, hs_p0, vs_p0, frame_p0, line_p0;

  always_comb begin
    x_nxt = x_p0 + 16'd1;
    y_nxt = y_p0;
    if (x_p0 == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_p0 == V_LAST) ? '0 : y_p0 + 16'd1;
    end
  end

  // ---- stage 0: counters and flags decoded from the new position ----
  // Reset parks at (0,0) with everything inactive, so the first strobe
  // after release moves to x=1 without a frame pulse for the parked spot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_p0     <= '0;
      y_p0     <= '0;
      vld_p0   <= 1'b0;
      hs_p0    <= 1'b0;
      vs_p0    <= 1'b0;
      frame_p0 <= 1'b0;
      line_p0  <= 1'b0;
    end else if (scan.i_pix_stb) begin
      x_p0     <= x_nxt;
      y_p0     <= y_nxt;
      vld_p0   <= (x_nxt < H_ACT) && (y_nxt < V_ACT);
      hs_p0    <= in_window(x_nxt, HS_BEG, HS_END);
      vs_p0    <= in_window(y_nxt, VS_BEG, VS_END);
      frame_p0 <= (x_nxt == '0) && (y_nxt == '0);
      line_p0  <= (x_nxt == '0);
    end else begin
      frame_p0 <= 1'b0;
      line_p0  <= 1'b0;
    end
  end

  assign scan.o_x     = $signed(x_p0);
  assign scan.o_y     = $signed(y_p0);
  assign scan.o_de    = vld_p0;
  assign scan.o_frame = frame_p0;
  assign scan.o_line  = line_p0;

  // ---- stage 1: PIX_LAT-deep delay of {de, hs, vs}, free-running ----
  // Shifts every clk regardless of strobe so the delay is measured in clk
  // cycles, matching the display logic's read latency.
  logic vld_d, hs_d, vs_d;

  generate
    if (PIX_LAT == 0) begin : g_no_dly
      assign vld_d = vld_p0;
      assign hs_d  = hs_p0;
      assign vs_d  = vs_p0;
    end else begin : g_dly
      logic [2:0] dly_p1 [PIX_LAT];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIX_LAT; i++) dly_p1[i] <= 3'b000;
        end else begin
          dly_p1[0] <= {vld_p0, hs_p0, vs_p0};
          for (int i = 1; i < PIX_LAT; i++) dly_p1[i] <= dly_p1[i-1];
        end
      end

      assign {vld_d, hs_d, vs_d} = dly_p1[PIX_LAT-1];
    end
  endgenerate

  // ---- stage 2: connector output register ----
  logic [7:0] r_p2, g_p2, b_p2;
  logic       hs_p2, vs_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p2  <= 8'd0;
      g_p2  <= 8'd0;
      b_p2  <= 8'd0;
      hs_p2 <= ~H_POL;
      vs_p2 <= ~V_POL;
    end else begin
      r_p2  <= blank_colour(vld_d, scan.i_red);
      g_p2  <= blank_colour(vld_d, scan.i_green);
      b_p2  <= blank_colour(vld_d, scan.i_blue);
      hs_p2 <= sync_level(hs_d, H_POL);
      vs_p2 <= sync_level(vs_d, V_POL);
    end
  end

  assign scan.vga_r  = r_p2;
  assign scan.vga_g  = g_p2;
  assign scan.vga_b  = b_p2;
  assign scan.vga_hs = hs_p2;
  assign scan.vga_vs = vs_p2;

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing
//   Directed bench for vga_scan_timing. Horizontal timing uses the full
//   800-pixel line; the vertical raster is shortened (4 active, 1 front
//   porch, 2 sync, 2 back porch = 9 lines) so whole frames fit in a short
//   run. The display logic is modelled as a one-clock ROM: colour for a
//   position is returned one clock after o_x shows it.
module tb_vga_scan_timing;

  localparam int HT      = 800;
  localparam int HACT    = 640;
  localparam int HS_B    = 656;
  localparam int HS_E    = 752;
  localparam int VT      = 9;
  localparam int VACT    = 4;
  localparam int VS_B    = 5;
  localparam int VS_E    = 7;

  logic clk;
  logic rst;

  vga_scan_timing_if bus();

  vga_scan_timing #(
    .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: position after the latest edge and two edges back
  int       ex, ey;
  bit       efr, eln;
  bit       s_de, s_hs, s_vs;  logic [7:0] s_x;
  bit       h1_de, h1_hs, h1_vs; logic [7:0] h1_x;
  bit       h2_de, h2_hs, h2_vs; logic [7:0] h2_x;
  bit       force_ff, drv_ff;
  logic [7:0] prev_ox;

  // statistics
  int  frame_cnt, line_cnt, vs_lo, r_ff;
  bit  meas_hs, hs_first;
  logic hs_prev;
  int  run_len;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, obs, obs, expv, expv);
    end
  endtask

  task automatic model_reset();
    ex = 0; ey = 0; efr = 0; eln = 0;
    s_de = 0; s_hs = 0; s_vs = 0; s_x = 8'd0;
    h1_de = 0; h1_hs = 0; h1_vs = 0; h1_x = 8'd0;
    h2_de = 0; h2_hs = 0; h2_vs = 0; h2_x = 8'd0;
  endtask

  task automatic clear_stats();
    frame_cnt = 0; line_cnt = 0; vs_lo = 0; r_ff = 0;
  endtask

  task automatic drive_colour();
    drv_ff = force_ff;
    bus.i_red   = force_ff ? 8'hFF : prev_ox;
    bus.i_green = force_ff ? 8'hFF : (prev_ox ^ 8'h5A);
    bus.i_blue  = force_ff ? 8'hFF : ~prev_ox;
    prev_ox     = bus.o_x[7:0];
  endtask

  // One clock: drive strobe, step the model, compare every output.
  task automatic tick(input bit stb);
    logic [7:0] er, eg, eb;
    bus.i_pix_stb = stb;
    @(posedge clk);
    @(negedge clk);
    h2_de = h1_de; h2_hs = h1_hs; h2_vs = h1_vs; h2_x = h1_x;
    h1_de = s_de;  h1_hs = s_hs;  h1_vs = s_vs;  h1_x = s_x;
    efr = 0; eln = 0;
    if (stb) begin
      if (ex == HT - 1) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      s_de = (ex < HACT) && (ey < VACT);
      s_hs = (ex >= HS_B) && (ex < HS_E);
      s_vs = (ey >= VS_B) && (ey < VS_E);
      efr  = (ex == 0) && (ey == 0);
      eln  = (ex == 0);
    end
    s_x = 8'(ex);
    er = h2_de ? (drv_ff ? 8'hFF : h2_x)           : 8'd0;
    eg = h2_de ? (drv_ff ? 8'hFF : (h2_x ^ 8'h5A)) : 8'd0;
    eb = h2_de ? (drv_ff ? 8'hFF : ~h2_x)          : 8'd0;
    chk("o_x",     32'(bus.o_x),     32'(ex));
    chk("o_y",     32'(bus.o_y),     32'(ey));
    chk("o_de",    32'(bus.o_de),    32'(s_de));
    chk("o_frame", 32'(bus.o_frame), 32'(efr));
    chk("o_line",  32'(bus.o_line),  32'(eln));
    chk("vga_hs",  32'(bus.vga_hs),  32'(!h2_hs));
    chk("vga_vs",  32'(bus.vga_vs),  32'(!h2_vs));
    chk("vga_r",   32'(bus.vga_r),   32'(er));
    chk("vga_g",   32'(bus.vga_g),   32'(eg));
    chk("vga_b",   32'(bus.vga_b),   32'(eb));
    frame_cnt += int'(bus.o_frame === 1'b1);
    line_cnt  += int'(bus.o_line === 1'b1);
    vs_lo     += int'(bus.vga_vs === 1'b0);
    r_ff      += int'(bus.vga_r === 8'hFF);
    if (meas_hs) begin
      if (bus.vga_hs === hs_prev) begin
        run_len++;
      end else begin
        if (!hs_first)
          chk(hs_prev ? "hs_high_width" : "hs_low_width", 32'(run_len),
              hs_prev ? 32'd704 : 32'd96);
        hs_first = 0;
        run_len  = 1;
        hs_prev  = bus.vga_hs;
      end
    end
    drive_colour();
  endtask

  // Called at a falling edge: raise reset mid-cycle, check the outputs
  // before any clock edge, hold over one edge, release on a falling edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_o_x",     32'(bus.o_x),     32'd0);
    chk("rst_o_y",     32'(bus.o_y),     32'd0);
    chk("rst_o_de",    32'(bus.o_de),    32'd0);
    chk("rst_o_frame", 32'(bus.o_frame), 32'd0);
    chk("rst_o_line",  32'(bus.o_line),  32'd0);
    chk("rst_vga_r",   32'(bus.vga_r),   32'd0);
    chk("rst_vga_g",   32'(bus.vga_g),   32'd0);
    chk("rst_vga_b",   32'(bus.vga_b),   32'd0);
    chk("rst_vga_hs",  32'(bus.vga_hs),  32'd1);
    chk("rst_vga_vs",  32'(bus.vga_vs),  32'd1);
    bus.i_pix_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_o_x", 32'(bus.o_x), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int first_hs;
    rst = 1'b0;
    bus.i_pix_stb = 1'b0;
    bus.i_red = 8'd0; bus.i_green = 8'd0; bus.i_blue = 8'd0;
    prev_ox = 8'd0; force_ff = 0; drv_ff = 0; meas_hs = 0;
    hs_first = 1; hs_prev = 1'b1; run_len = 0;
    model_reset();

    // reset from power-up with strobe held high
    @(negedge clk);
    async_reset();

    // one full frame at stb=1 with line-width measurement
    clear_stats();
    meas_hs = 1; hs_first = 1; hs_prev = bus.vga_hs; run_len = 1;
    for (int i = 1; i <= VT * HT; i++) begin
      tick(1'b1);
      if (i == 1) begin
        chk("first_stb_x", 32'(bus.o_x), 32'd1);
        chk("first_stb_frame", 32'(bus.o_frame), 32'd0);
      end
      if (i == 799) begin
        chk("x_799", 32'(bus.o_x), 32'd799);
        chk("y_at_799", 32'(bus.o_y), 32'd0);
      end
      if (i == 800) begin
        chk("x_wrap", 32'(bus.o_x), 32'd0);
        chk("y_inc", 32'(bus.o_y), 32'd1);
      end
    end
    chk("frame_end_x", 32'(bus.o_x), 32'd0);
    chk("frame_end_y", 32'(bus.o_y), 32'd0);
    chk("frame_end_pulse", 32'(bus.o_frame), 32'd1);
    chk("frame_pulses", 32'(frame_cnt), 32'd1);
    chk("line_pulses", 32'(line_cnt), 32'd9);
    chk("vs_low_clks", 32'(vs_lo), 32'd1600);

    // second frame with the display logic returning FF everywhere
    clear_stats();
    force_ff = 1;
    for (int i = 0; i < VT * HT; i++) tick(1'b1);
    chk("ff_visible_pixels", 32'(r_ff), 32'(HACT * VACT));
    chk("ff_frame_pulses", 32'(frame_cnt), 32'd1);
    force_ff = 0;
    meas_hs = 0;

    // strobe one clock in four
    clear_stats();
    for (int i = 0; i < 4 * VT * HT; i++) tick((i % 4) == 3);
    chk("div4_frame_pulses", 32'(frame_cnt), 32'd1);
    chk("div4_line_pulses", 32'(line_cnt), 32'd9);
    chk("div4_vs_low_clks", 32'(vs_lo), 32'd6400);
    chk("div4_end_frame", 32'(bus.o_frame), 32'd1);

    // reset in the middle of a frame
    for (int i = 0; i < 2 * HT + 300; i++) tick(1'b1);
    chk("mid_x", 32'(bus.o_x), 32'd300);
    chk("mid_y", 32'(bus.o_y), 32'd2);
    async_reset();
    first_hs = -1;
    for (int i = 1; i <= 700; i++) begin
      tick(1'b1);
      if (first_hs < 0 && bus.vga_hs === 1'b0) begin
        first_hs = i;
        chk("first_hs_o_x", 32'(bus.o_x), 32'd658);
      end
    end
    chk("first_hs_tick", 32'(first_hs), 32'd658);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
